// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the datapath and the pipeline control unit.
// master: control unit (reads hazard fields, drives latch controls and counters); slave: datapath.
interface hazard_ctrl_if #(
    parameter int REGW = 5,
    parameter int CNTW = 16
);
    logic            ihit;
    logic            dhit;
    logic            dmem_req;
    logic            idex_memread;
    logic [REGW-1:0] idex_rd;
    logic [REGW-1:0] ifid_rs;
    logic [REGW-1:0] ifid_rt;
    logic            ifid_uses_rt;
    logic            redirect;
    logic            halt_wb;
    logic            pc_en;
    logic            ifid_en;
    logic            ifid_flush;
    logic            idex_flush;
    logic            exmem_en;
    logic            halted;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] bubble_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        input  ihit, dhit, dmem_req, idex_memread, idex_rd,
        input  ifid_rs, ifid_rt, ifid_uses_rt, redirect, halt_wb,
        output pc_en, ifid_en, ifid_flush, idex_flush, exmem_en,
        output halted, stall_cnt, bubble_cnt, flush_cnt
    );

    modport slave (
        output ihit, dhit, dmem_req, idex_memread, idex_rd,
        output ifid_rs, ifid_rt, ifid_uses_rt, redirect, halt_wb,
        input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_en,
        input  halted, stall_cnt, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use bubbles, D-miss stalls, redirect flushes, HALT freeze.
// Ports: CLK, RST (async active-high), hif (hazard_ctrl_if.master) with inputs/controls/counters.
module hazard_ctrl #(
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_ctrl_if.master hif
);
    typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

    state_t          state, nstate;
    logic [REGW-1:0] rd, rs, rt;
    logic            luse, miss;
    logic            pc_en, ifid_en, ifid_flush, idex_flush, exmem_en;
    logic            stall_inc, bubble_inc, flush_inc;
    logic [CNTW-1:0] stall_q, bubble_q, flush_q;

    assign rd = hif.idex_rd;
    assign rs = hif.ifid_rs;
    assign rt = hif.ifid_rt;

    // r0 is hardwired zero, so a load into it never feeds a consumer
    assign luse = hif.idex_memread && (rd != '0) &&
                  ((rd == rs) || (hif.ifid_uses_rt && (rd == rt)));
    assign miss = hif.dmem_req && !hif.dhit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= nstate;
    end

    always_comb begin
        nstate     = state;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        stall_inc  = 1'b0;
        bubble_inc = 1'b0;
        flush_inc  = 1'b0;
        unique case (state)
            RUN: begin
                if (hif.halt_wb) begin
                    nstate   = HALT;
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    exmem_en = 1'b0;
                end else if (miss) begin
                    nstate   = DWAIT;
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    exmem_en = 1'b0;
                end else if (hif.redirect) begin
                    // ID is being flushed, so any load-use in it is moot
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = hif.ihit;
                end else if (luse) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    bubble_inc = hif.ihit;
                end
            end
            DWAIT: begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                exmem_en  = hif.dhit;
                stall_inc = 1'b1;
                if (hif.dhit) nstate = RUN;
            end
            HALT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                exmem_en = 1'b0;
            end
            default: nstate = RUN;
        endcase
    end

    function automatic logic [CNTW-1:0] bump(input logic [CNTW-1:0] c,
                                             input logic en);
        return (en && (c != '1)) ? c + 1'b1 : c;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            stall_q  <= bump(stall_q, stall_inc);
            bubble_q <= bump(bubble_q, bubble_inc);
            flush_q  <= bump(flush_q, flush_inc);
        end
    end

    assign hif.pc_en      = pc_en;
    assign hif.ifid_en    = ifid_en;
    assign hif.ifid_flush = ifid_flush;
    assign hif.idex_flush = idex_flush;
    assign hif.exmem_en   = exmem_en;
    assign hif.halted     = (state == HALT);
    assign hif.stall_cnt  = stall_q;
    assign hif.bubble_cnt = bubble_q;
    assign hif.flush_cnt  = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
// Two instances (16-bit and 2-bit counters) share the same stimulus.
module tb_hazard_ctrl;
    localparam int REGW = 5;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    bit   run_cmp = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl_if #(.REGW(REGW), .CNTW(16)) h16 ();
    hazard_ctrl_if #(.REGW(REGW), .CNTW(2))  h2 ();

    hazard_ctrl #(.REGW(REGW), .CNTW(16)) dut16 (.CLK(CLK), .RST(RST), .hif(h16));
    hazard_ctrl #(.REGW(REGW), .CNTW(2))  dut2  (.CLK(CLK), .RST(RST), .hif(h2));

    assign h2.ihit         = h16.ihit;
    assign h2.dhit         = h16.dhit;
    assign h2.dmem_req     = h16.dmem_req;
    assign h2.idex_memread = h16.idex_memread;
    assign h2.idex_rd      = h16.idex_rd;
    assign h2.ifid_rs      = h16.ifid_rs;
    assign h2.ifid_rt      = h16.ifid_rt;
    assign h2.ifid_uses_rt = h16.ifid_uses_rt;
    assign h2.redirect     = h16.redirect;
    assign h2.halt_wb      = h16.halt_wb;

    // ---------------- behavioural model ----------------
    localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;
    int mode = M_RUN;
    int stalls = 0, bubbles = 0, flushes = 0;

    // control vector order: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en}
    localparam logic [4:0] C_GO   = 5'b11001;
    localparam logic [4:0] C_BUB  = 5'b00011;
    localparam logic [4:0] C_FL   = 5'b11111;
    localparam logic [4:0] C_HOLD = 5'b00000;

    function automatic bit load_use();
        int src[$];
        if (!h16.idex_memread || h16.idex_rd == 0) return 1'b0;
        src.push_back(int'(h16.ifid_rs));
        if (h16.ifid_uses_rt) src.push_back(int'(h16.ifid_rt));
        foreach (src[i]) if (src[i] == int'(h16.idex_rd)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [4:0] exp_ctrl();
        if (mode == M_HALT) return C_HOLD;
        if (mode == M_WAIT) return h16.dhit ? 5'b00001 : C_HOLD;
        if (h16.halt_wb) return C_HOLD;
        if (h16.dmem_req && !h16.dhit) return C_HOLD;
        if (h16.redirect) return C_FL;
        if (load_use()) return C_BUB;
        return C_GO;
    endfunction

    function automatic int sat(input int c, input int w);
        int top = (1 << w) - 1;
        return (c > top) ? top : c;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode = M_RUN;
            stalls = 0;
            bubbles = 0;
            flushes = 0;
        end else if (mode == M_WAIT) begin
            stalls++;
            if (h16.dhit) mode = M_RUN;
        end else if (mode == M_RUN) begin
            if (h16.halt_wb) mode = M_HALT;
            else if (h16.dmem_req && !h16.dhit) mode = M_WAIT;
            else if (h16.redirect) begin
                if (h16.ihit) flushes++;
            end else if (load_use() && h16.ihit) bubbles++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (run_cmp) begin
            logic [4:0] e;
            e = exp_ctrl();
            chk("ctrl16", {h16.pc_en, h16.ifid_en, h16.ifid_flush,
                           h16.idex_flush, h16.exmem_en}, e);
            chk("ctrl2", {h2.pc_en, h2.ifid_en, h2.ifid_flush,
                          h2.idex_flush, h2.exmem_en}, e);
            chk("halted16", h16.halted, mode == M_HALT);
            chk("halted2", h2.halted, mode == M_HALT);
            chk("stall16", h16.stall_cnt, sat(stalls, 16));
            chk("bubble16", h16.bubble_cnt, sat(bubbles, 16));
            chk("flush16", h16.flush_cnt, sat(flushes, 16));
            chk("stall2", h2.stall_cnt, sat(stalls, 2));
            chk("bubble2", h2.bubble_cnt, sat(bubbles, 2));
            chk("flush2", h2.flush_cnt, sat(flushes, 2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit ih, input bit dh, input bit dreq,
                          input bit mr, input int rd, input int rs,
                          input int rt, input bit urt, input bit redir,
                          input bit hw);
        h16.ihit = ih;
        h16.dhit = dh;
        h16.dmem_req = dreq;
        h16.idex_memread = mr;
        h16.idex_rd = REGW'(rd);
        h16.ifid_rs = REGW'(rs);
        h16.ifid_rt = REGW'(rt);
        h16.ifid_uses_rt = urt;
        h16.redirect = redir;
        h16.halt_wb = hw;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_pc_en", h16.pc_en, 1'b1);
        chk("rst_exmem", h16.exmem_en, 1'b1);
        chk("rst_halted", h16.halted, 1'b0);
        chk("rst_cnts", {h16.stall_cnt, h16.bubble_cnt}, 32'h0);
        tick();
        RST = 1'b0;
    endtask

    task automatic rand_in();
        set_in($urandom_range(3) != 0, $urandom_range(1), $urandom_range(2) == 0,
               $urandom_range(1), $urandom_range(3), $urandom_range(3),
               $urandom_range(3), $urandom_range(1), $urandom_range(4) == 0,
               $urandom_range(63) == 0);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 RST = 1'b1;
        run_cmp = 1'b1;
        tick();
        do_reset();

        // T1: load-use on rs
        set_in(1, 0, 0, 1, 8, 8, 3, 0, 0, 0);
        @(negedge CLK);
        chk("T1_ctrl", {h16.pc_en, h16.ifid_en, h16.idex_flush}, 3'b001);
        tick();
        chk("T1_bubble", h16.bubble_cnt, 1);

        // T2: rd=0 never hazards
        do_reset();
        set_in(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        @(negedge CLK);
        chk("T2_ctrl", {h16.pc_en, h16.ifid_en, h16.idex_flush}, 3'b110);
        tick();
        chk("T2_bubble", h16.bubble_cnt, 0);

        // T3: 4 miss cycles then hit
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge CLK);
            chk("T3_hold", {h16.pc_en, h16.ifid_en, h16.exmem_en}, 3'b000);
            tick();
        end
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("T3_hit", {h16.pc_en, h16.exmem_en}, 2'b01);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("T3_stall", h16.stall_cnt, 4);
        chk("T3_run", h16.pc_en, 1'b1);
        tick();

        // T4: redirect beats load-use, ihit low twice
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(i == 2, 0, 0, 1, 5, 5, 0, 0, 1, 0);
            @(negedge CLK);
            chk("T4_ctrl", {h16.pc_en, h16.ifid_flush, h16.idex_flush}, 3'b111);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("T4_flush", h16.flush_cnt, 1);
        chk("T4_bubble", h16.bubble_cnt, 0);

        // T5: HALT is sticky until reset
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            rand_in();
            @(negedge CLK);
            chk("T5_halted", h16.halted, 1'b1);
            chk("T5_en", {h16.pc_en, h16.ifid_en, h16.exmem_en}, 3'b000);
            tick();
        end
        chk("T5_frozen", h16.flush_cnt, 2);
        do_reset();
        chk("T5_cleared", {h16.halted, h16.flush_cnt}, 0);

        // T6: 2-bit counter saturation
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 1, 7, 2, 7, 1, 0, 0);
            tick();
        end
        chk("T6_sat2", h2.bubble_cnt, 3);
        chk("T6_wide", h16.bubble_cnt, 5);

        // random traffic with occasional async reset
        for (int n = 0; n < 4000; n++) begin
            if ((mode == M_HALT && $urandom_range(7) == 0) ||
                $urandom_range(299) == 0) begin
                do_reset();
            end else begin
                rand_in();
                tick();
            end
        end

        @(negedge CLK);
        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
